// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer: iterative MULT/DIV sequencer owning the architectural HI/LO registers
module hilo_muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            CLOCK,
   input  logic            RESET,
   input  logic            Start_IN,
   input  logic [2:0]      Op_IN,
   input  logic [XLEN-1:0] OperandA_IN,
   input  logic [XLEN-1:0] OperandB_IN,
   input  logic            ReadHILO_IN,
   input  logic            Flush_IN,
   output logic            Busy_OUT,
   output logic            Stall_OUT,
   output logic            Done_OUT,
   output logic [XLEN-1:0] HI_OUT,
   output logic [XLEN-1:0] LO_OUT
);
   localparam int CW = $clog2(XLEN);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t            state_q;
   logic [CW-1:0]     count_q;
   logic              div_q, neg_q, rneg_q, done_q;
   logic [XLEN-1:0]   a_q, b_q, hi_q, lo_q, hi_d, lo_d, quo, rem, sub, a_mag, b_mag;
   logic [2*XLEN-1:0] p_q, p_d, prod;
   logic [XLEN:0]     sum;
   logic              ge, a_neg, b_neg;
   // Signed ops work on magnitudes; unsigned ops pass operands through raw
   assign a_neg = ~Op_IN[0] & OperandA_IN[XLEN-1];
   assign b_neg = ~Op_IN[0] & OperandB_IN[XLEN-1];
   assign a_mag = a_neg ? -OperandA_IN : OperandA_IN;
   assign b_mag = b_neg ? -OperandB_IN : OperandB_IN;
   // One shift-add or restoring-divide step, plus the final sign fix-up of the result
   always_comb begin
      sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
      ge   = p_q[2*XLEN-1:XLEN-1] >= {1'b0, b_q};
      sub  = p_q[2*XLEN-2:XLEN-1] - b_q;
      p_d  = div_q ? (ge ? {sub, p_q[XLEN-2:0], 1'b1} : {p_q[2*XLEN-2:0], 1'b0})
                   : (p_q[0] ? {sum, p_q[XLEN-1:1]} : {1'b0, p_q[2*XLEN-1:1]});
      prod = neg_q ? -p_q : p_q;
      quo  = (b_q == '0) ? '1 : (neg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0]);
      rem  = rneg_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
      {hi_d, lo_d} = div_q ? {rem, quo} : prod;
   end
   // Sequencer FSM: accept in IDLE, iterate XLEN times in RUN, commit in FIX
   always_ff @(posedge CLOCK or negedge RESET)
      if (!RESET) begin
         state_q <= IDLE;
         count_q <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         done_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (Flush_IN) begin
            state_q <= IDLE;
            count_q <= '0;
         end else
            case (state_q)
               IDLE:
                  if (Start_IN) begin
                     if (Op_IN == 3'b100) hi_q <= OperandA_IN;
                     else if (Op_IN == 3'b101) lo_q <= OperandA_IN;
                     else if (!Op_IN[2]) begin
                        div_q   <= Op_IN[1];
                        neg_q   <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        a_q     <= a_mag;
                        b_q     <= b_mag;
                        p_q     <= {{XLEN{1'b0}}, Op_IN[1] ? a_mag : b_mag};
                        count_q <= '0;
                        state_q <= RUN;
                     end
                  end
               RUN: begin
                  p_q     <= p_d;
                  count_q <= count_q + 1'b1;
                  if (count_q == CW'(XLEN-1)) state_q <= FIX;
               end
               FIX: begin
                  hi_q    <= hi_d;
                  lo_q    <= lo_d;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
      end
   assign Busy_OUT  = state_q != IDLE;
   assign Stall_OUT = (Start_IN | ReadHILO_IN) & Busy_OUT;
   assign Done_OUT  = done_q;
   assign HI_OUT    = hi_q;
   assign LO_OUT    = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// tb_hilo_muldiv_sequencer: directed vectors against an arithmetic HI/LO reference model
module tb_hilo_muldiv_sequencer;
   logic        CLOCK = 0, RESET = 0, Start_IN = 0, ReadHILO_IN = 0, Flush_IN = 0;
   logic [2:0]  Op_IN = 0;
   logic [31:0] OperandA_IN = 0, OperandB_IN = 0;
   logic        Busy_OUT, Stall_OUT, Done_OUT;
   logic [31:0] HI_OUT, LO_OUT;

   hilo_muldiv_sequencer #(.XLEN(32)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .Start_IN(Start_IN), .Op_IN(Op_IN),
      .OperandA_IN(OperandA_IN), .OperandB_IN(OperandB_IN), .ReadHILO_IN(ReadHILO_IN),
      .Flush_IN(Flush_IN), .Busy_OUT(Busy_OUT), .Stall_OUT(Stall_OUT), .Done_OUT(Done_OUT),
      .HI_OUT(HI_OUT), .LO_OUT(LO_OUT));

   always #5 CLOCK = ~CLOCK;

   int vectors = 0, errors = 0;
   bit armed = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference results straight from the arithmetic definition of each op
   function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      case (op)
         3'd0: return 64'(longint'(sa) * longint'(sb));
         3'd1: return {32'b0, a} * {32'b0, b};
         3'd2: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         3'd3: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: return 64'h0;
      endcase
   endfunction

   // Model: an accepted MULT/DIV keeps the unit busy 33 cycles, then results land with a Done pulse
   int          left = 0;
   logic        m_done = 0;
   logic [31:0] m_hi = 0, m_lo = 0;
   logic [63:0] m_res = 0;
   always @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         left = 0; m_done = 0; m_hi = 0; m_lo = 0;
      end else begin
         m_done = 0;
         if (Flush_IN) left = 0;
         else if (left > 0) begin
            left--;
            if (left == 0) begin
               {m_hi, m_lo} = m_res;
               m_done = 1;
            end
         end else if (Start_IN) begin
            if (Op_IN == 3'd4) m_hi = OperandA_IN;
            else if (Op_IN == 3'd5) m_lo = OperandA_IN;
            else if (!Op_IN[2]) begin
               m_res = model_result(Op_IN, OperandA_IN, OperandB_IN);
               left = 33;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge CLOCK)
      if (armed) begin
         chk("busy", 64'(Busy_OUT), 64'(left > 0));
         chk("stall", 64'(Stall_OUT), 64'((Start_IN | ReadHILO_IN) && left > 0));
         chk("done", 64'(Done_OUT), 64'(m_done));
         chk("hi", 64'(HI_OUT), 64'(m_hi));
         chk("lo", 64'(LO_OUT), 64'(m_lo));
      end

   // Issue one op for a single cycle; return busy-cycle count and cycle offset of Done (-1 on timeout)
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cyc, output int done_at);
      @(posedge CLOCK); #1;
      Start_IN = 1; Op_IN = op; OperandA_IN = a; OperandB_IN = b;
      @(posedge CLOCK); #1;
      Start_IN = 0;
      busy_cyc = 0;
      done_at = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge CLOCK);
         if (Busy_OUT) busy_cyc++;
         if (Done_OUT) begin
            done_at = k;
            break;
         end
         @(posedge CLOCK); #1;
      end
   endtask

   task automatic op_check(input string name, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
      int bc, da;
      run_op(op, a, b, bc, da);
      chk({name, "_busy_cycles"}, 64'(bc), 64'd33);
      chk({name, "_done_at"}, 64'(da), 64'd34);
      chk({name, "_hi"}, 64'(HI_OUT), 64'(hi));
      chk({name, "_lo"}, 64'(LO_OUT), 64'(lo));
   endtask

   initial begin
      int dn;
      repeat (3) @(posedge CLOCK);
      #1 RESET = 1;
      armed = 1;
      chk("reset_hi", 64'(HI_OUT), 64'h0);
      chk("reset_lo", 64'(LO_OUT), 64'h0);
      chk("reset_busy", 64'(Busy_OUT), 64'h0);
      chk("reset_done", 64'(Done_OUT), 64'h0);

      op_check("mult_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      op_check("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      // MTLO in the Done cycle
      Start_IN = 1; Op_IN = 3'd5; OperandA_IN = 32'h1234;
      @(posedge CLOCK); #1;
      Start_IN = 0;
      chk("mtlo_lo", 64'(LO_OUT), 64'h1234);
      chk("mtlo_hi", 64'(HI_OUT), 64'hFFFF_FFFE);

      op_check("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      op_check("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'hE);
      op_check("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      op_check("divu_zero", 3'd3, 32'h55, 32'h0, 32'h55, 32'hFFFF_FFFF);
      op_check("div_zero", 3'd2, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
      op_check("div_pos_negb", 3'd2, 32'd20, 32'hFFFF_FFFA, 32'd2, 32'hFFFF_FFFD);

      // Stall while busy; second op held from c+5 is accepted in the Done cycle
      @(posedge CLOCK); #1;
      Start_IN = 1; Op_IN = 3'd0; OperandA_IN = 32'd3; OperandB_IN = 32'd5;
      @(posedge CLOCK); #1;
      Start_IN = 0;
      repeat (4) @(posedge CLOCK);
      #1;
      Start_IN = 1; Op_IN = 3'd1; OperandA_IN = 32'h1_0000; OperandB_IN = 32'h1_0000; ReadHILO_IN = 1;
      for (int k = 5; k <= 34; k++) begin
         @(negedge CLOCK);
         if (k == 5) chk("stall_c5", 64'(Stall_OUT), 64'h1);
         if (k == 33) chk("stall_c33", 64'(Stall_OUT), 64'h1);
         if (k == 34) begin
            chk("stall_c34", 64'(Stall_OUT), 64'h0);
            chk("done_c34", 64'(Done_OUT), 64'h1);
            chk("first_lo", 64'(LO_OUT), 64'hF);
         end
         @(posedge CLOCK); #1;
      end
      Start_IN = 0; ReadHILO_IN = 0;
      dn = -1;
      for (int k = 35; k <= 75; k++) begin
         @(negedge CLOCK);
         if (Done_OUT) begin
            dn = k;
            break;
         end
         @(posedge CLOCK); #1;
      end
      chk("second_done_at", 64'(dn), 64'd68);
      chk("second_hi", 64'(HI_OUT), 64'h1);
      chk("second_lo", 64'(LO_OUT), 64'h0);

      // Flush at count=10
      @(posedge CLOCK); #1;
      Start_IN = 1; Op_IN = 3'd0; OperandA_IN = 32'd2; OperandB_IN = 32'd3;
      @(posedge CLOCK); #1;
      Start_IN = 0;
      repeat (10) @(posedge CLOCK);
      #1 Flush_IN = 1;
      @(posedge CLOCK); #1;
      Flush_IN = 0;
      chk("flush_busy", 64'(Busy_OUT), 64'h0);
      chk("flush_hi", 64'(HI_OUT), 64'h1);
      chk("flush_lo", 64'(LO_OUT), 64'h0);
      dn = 0;
      repeat (40) begin
         @(negedge CLOCK);
         dn += int'(Done_OUT);
      end
      chk("flush_no_done", 64'(dn), 64'h0);

      // Flush beats a same-cycle MTHI
      Start_IN = 1; Op_IN = 3'd4; OperandA_IN = 32'hDEAD; Flush_IN = 1;
      @(posedge CLOCK); #1;
      Start_IN = 0; Flush_IN = 0;
      chk("flush_mthi_hi", 64'(HI_OUT), 64'h1);

      // Reserved opcode leaves everything alone
      Start_IN = 1; Op_IN = 3'd6; OperandA_IN = 32'h55;
      @(posedge CLOCK); #1;
      Start_IN = 0;
      chk("op6_busy", 64'(Busy_OUT), 64'h0);
      chk("op6_hi", 64'(HI_OUT), 64'h1);
      chk("op6_lo", 64'(LO_OUT), 64'h0);

      // MTHI in idle
      Start_IN = 1; Op_IN = 3'd4; OperandA_IN = 32'hCAFE;
      @(posedge CLOCK); #1;
      Start_IN = 0;
      chk("mthi_hi", 64'(HI_OUT), 64'hCAFE);

      // Asynchronous reset at count=20, checked before any clock edge
      Start_IN = 1; Op_IN = 3'd0; OperandA_IN = 32'd9; OperandB_IN = 32'd9;
      @(posedge CLOCK); #1;
      Start_IN = 0;
      repeat (20) @(posedge CLOCK);
      #2 RESET = 0;
      #1;
      chk("async_rst_busy", 64'(Busy_OUT), 64'h0);
      chk("async_rst_hi", 64'(HI_OUT), 64'h0);
      chk("async_rst_lo", 64'(LO_OUT), 64'h0);
      @(negedge CLOCK);
      #1 RESET = 1;
      repeat (3) @(posedge CLOCK);
      #1;
      chk("post_rst_busy", 64'(Busy_OUT), 64'h0);
      op_check("post_rst_mult", 3'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0, 32'h6);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
